power_result_fifo: RTL and testbench

- Downstream stage of the `power` block. It captures each completed result: `result[31:0]`, the overflow flag and the underflow flag.
- Capture happens when `power` raises its `enable` (done) output.
- Each captured result is tagged with an IEEE754 class code and held in a small FIFO.
- Results are presented to the consumer over a valid/ready handshake, so the calculator front-end can drain them at its own pace.

---
 rtl/power_result_fifo.sv | 119 +++++++++++
 tb/tb_power_result_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/power_result_fifo.sv
// Result capture FIFO behind the power unit: edge-detects done, classifies the
// IEEE754 result and queues it for a valid/ready consumer (first-word fall-through).
module power_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          done_in,
    input  logic [31:0]   result_in,
    input  logic          overflow_in,
    input  logic          underflow_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic          out_overflow,
    output logic          out_underflow,
    output logic [2:0]    out_class,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [7:0]    drop_cnt
);

    localparam logic [AW:0] full_lvl = (AW+1)'(DEPTH);
    localparam int          ent_w    = 37;

    localparam logic [2:0] cls_zero = 3'b000;
    localparam logic [2:0] cls_sub  = 3'b001;
    localparam logic [2:0] cls_norm = 3'b010;
    localparam logic [2:0] cls_inf  = 3'b011;
    localparam logic [2:0] cls_nan  = 3'b100;

    logic [ent_w-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             done_q;
    logic             capture;
    logic             push;
    logic             pop;
    logic             drop;
    logic [2:0]       in_class;
    logic [7:0]       exp_f;
    logic [22:0]      man_f;
    logic [ent_w-1:0] head;

    assign exp_f = result_in[30:23];
    assign man_f = result_in[22:0];

    always_comb begin
        in_class = cls_norm;
        if (exp_f == 8'd0) begin
            in_class = (man_f == 23'd0) ? cls_zero : cls_sub;
        end else if (exp_f == 8'hFF) begin
            in_class = (man_f == 23'd0) ? cls_inf : cls_nan;
        end
    end

    assign full      = (count == full_lvl);
    assign empty     = (count == '0);
    assign out_valid = ~empty;

    // done_in is a level; only its rising edge counts as a new result
    assign capture = done_in & ~done_q;
    assign pop     = out_valid & out_ready;
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {result_in, overflow_in, underflow_in, in_class};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage is never cleared, so gate the head so an empty FIFO reads zero
    assign head = empty ? '0 : mem[rd_ptr];

    assign out_result    = head[36:5];
    assign out_overflow  = head[4];
    assign out_underflow = head[3];
    assign out_class     = head[2:0];

endmodule

// File: tb/tb_power_result_fifo.sv
// Self-checking bench for power_result_fifo: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_power_result_fifo;

    typedef struct packed {
        logic [31:0] r;
        logic        ov;
        logic        un;
        logic [2:0]  c;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        done_in = 1'b0;
    logic [31:0] result_in = '0;
    logic        overflow_in = 1'b0;
    logic        underflow_in = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic [2:0]  out_class;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [7:0]  drop_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t q[$];
    logic m_done_q = 1'b0;
    int   m_drops  = 0;
    int   max_cnt  = 0;

    power_result_fifo #(.DEPTH(4), .AW(2)) dut (
        .CLK(CLK), .RST(RST), .done_in(done_in), .result_in(result_in),
        .overflow_in(overflow_in), .underflow_in(underflow_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .out_class(out_class), .count(count), .full(full), .empty(empty),
        .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] classify(input logic [31:0] r);
        int e;
        int m;
        e = int'(r[30:23]);
        m = int'(r[22:0]);
        if (e == 0)   return (m == 0) ? 3'd0 : 3'd1;
        if (e == 255) return (m == 0) ? 3'd3 : 3'd4;
        return 3'd2;
    endfunction

    task automatic check_outputs();
        ent_t h;
        h = (q.size() > 0) ? q[0] : '0;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("count", 32'(count), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == 4));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        check("out_result", out_result, h.r);
        check("out_overflow", 32'(out_overflow), 32'(h.ov));
        check("out_underflow", 32'(out_underflow), 32'(h.un));
        check("out_class", 32'(out_class), 32'(h.c));
    endtask

    // One clock cycle: drive at the falling edge, update model at the rising edge, check after it
    task automatic step(input logic d, input logic [31:0] r, input logic ov, input logic un, input logic rdy);
        bit   cap;
        bit   pp;
        int   sz;
        ent_t e;
        @(negedge CLK);
        done_in = d; result_in = r; overflow_in = ov; underflow_in = un; out_ready = rdy;
        @(posedge CLK);
        #1;
        cap = d && !m_done_q;
        m_done_q = d;
        sz = q.size();
        pp = (sz > 0) && rdy;
        if (pp) void'(q.pop_front());
        if (cap) begin
            if (sz < 4 || pp) begin
                e.r = r; e.ov = ov; e.un = un; e.c = classify(r);
                q.push_back(e);
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
        if (q.size() > max_cnt) max_cnt = q.size();
        check_outputs();
    endtask

    task automatic capture_one(input logic [31:0] r, input logic ov, input logic un);
        step(1'b1, r, ov, un, 1'b0);
        step(1'b0, r, ov, un, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        logic [31:0] vals[6];
        logic [31:0] rv;
        logic        d;

        #3;
        check_outputs();
        check("rst_out_result", out_result, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        // 1: long done pulse yields a single entry that holds while not ready
        for (int i = 0; i < 20; i++) step(1'b1, 32'h44DED0C8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t1_count", 32'(count), 32'd1);
        check("t1_class", 32'(out_class), 32'd2);
        check("t1_result", out_result, 32'h44DED0C8);
        drain();

        // 2: class coverage
        capture_one(32'h00000000, 1'b0, 1'b0);
        capture_one(32'h00000001, 1'b0, 1'b1);
        capture_one(32'h7F800000, 1'b1, 1'b0);
        capture_one(32'h7FC00000, 1'b0, 1'b0);
        check("t2_full", 32'(full), 32'd1);
        drain();
        check("t2_gated", out_result, 32'h0);

        // 3: overfill drops the last two
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        for (int i = 0; i < 6; i++) capture_one(vals[i], 1'b0, 1'b0);
        check("t3_drops", 32'(drop_cnt), 32'd2);

        // 4: full plus simultaneous capture and pop
        step(1'b1, 32'h41000000, 1'b0, 1'b0, 1'b1);
        check("t4_count", 32'(count), 32'd4);
        check("t4_drops", 32'(drop_cnt), 32'd2);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drain();

        // 5: wrap-around with immediate pops
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h42000000 + 32'(i), 1'b0, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        check("t5_maxcnt", 32'(max_cnt), 32'd1);

        // 6: async reset mid-stream, then capture on the first edge after release
        capture_one(32'h3F000000, 1'b0, 1'b0);
        capture_one(32'h3E800000, 1'b0, 1'b0);
        capture_one(32'h3E000000, 1'b0, 1'b0);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        done_in = 1'b1;
        result_in = 32'h40490FDB;
        #1;
        q.delete();
        m_done_q = 1'b0;
        m_drops = 0;
        check("t6_valid_async", 32'(out_valid), 32'd0);
        check("t6_count_async", 32'(count), 32'd0);
        check("t6_drop_async", 32'(drop_cnt), 32'd0);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        step(1'b1, 32'h40490FDB, 1'b0, 1'b0, 1'b0);
        check("t6_capture", 32'(count), 32'd1);
        step(1'b1, 32'h40490FDB, 1'b0, 1'b0, 1'b0);
        drain();

        // Random traffic
        d = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) d = ~d;
            case ($urandom_range(0, 5))
                0:       rv = {$urandom_range(0, 1) == 1, 31'h0};
                1:       rv = {1'b0, 8'h00, 23'($urandom_range(1, 1000))};
                2:       rv = 32'hFF800000;
                3:       rv = {1'b0, 8'hFF, 23'($urandom_range(1, 4000000))};
                default: rv = $urandom;
            endcase
            step(d, rv, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
